// File: rtl/player_motion_if.sv
// Signal bundle between the player control block and the motion generator.
// The master drives the step strobe and the button levels; the slave returns the position.
interface player_motion_if;
   logic       step;
   logic       left;
   logic       right;
   logic       jump;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic       grounded;
   logic       landed;

   modport master (
      output step, left, right, jump,
      input  x_out, y_out, grounded, landed
   );

   modport slave (
      input  step, left, right, jump,
      output x_out, y_out, grounded, landed
   );
endinterface

// File: rtl/player_motion.sv
// Player position generator: walk, jump, gravity with terminal velocity, clamped to the well.
// Advances once per step strobe; new x/y are registered and visible the cycle after the step.
module player_motion #(
   parameter logic [7:0] X_START  = 8'd3,
   parameter logic [6:0] Y_START  = 7'd3,
   parameter logic [7:0] X_MIN    = 8'd1,
   parameter logic [7:0] X_MAX    = 8'd156,
   parameter logic [6:0] Y_MIN    = 7'd1,
   parameter logic [6:0] Y_FLOOR  = 7'd116,
   parameter logic [2:0] HSTEP    = 3'd1,
   parameter logic [3:0] JUMP_V   = 4'd4,
   parameter logic [3:0] VY_MAX   = 4'd3,
   parameter logic [2:0] GRAV_DIV = 3'd2
) (
   input  logic            clk,
   input  logic            resetn,
   player_motion_if.slave  bus
);

   localparam logic [0:0] S_GROUND = 1'b0;
   localparam logic [0:0] S_AIR    = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [7:0]        x_q, x_d;
   logic [6:0]        y_q, y_d;
   logic signed [4:0] vy_q, vy_d;
   logic [2:0]        grav_q, grav_d;
   logic              pend_q, pend_d;
   logic              landed_q, landed_d;

   // Horizontal move in 9-bit signed so stepping left of zero cannot wrap.
   logic signed [8:0] x_cur, x_sum;
   logic [7:0]        x_clamped;

   assign x_cur = $signed({1'b0, x_q});

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      x_sum = x_cur;
      if (bus.right && !bus.left)
         x_sum = x_cur + $signed({6'd0, HSTEP});
      else if (bus.left && !bus.right)
         x_sum = x_cur - $signed({6'd0, HSTEP});

      if (x_sum < $signed({1'b0, X_MIN}))
         x_clamped = X_MIN;
      else if (x_sum > $signed({1'b0, X_MAX}))
         x_clamped = X_MAX;
      else
         x_clamped = x_sum[7:0];
   end

   // Vertical candidates in 8-bit signed; vy is negative when moving up.
   logic signed [7:0] y_cur, y_fall, y_rise, y_floor_s, y_min_s;
   logic signed [4:0] vy_grav, vy_max_s, vy_jump;
   logic              grav_wrap, jump_req;

   assign y_cur     = $signed({1'b0, y_q});
   assign y_fall    = y_cur + $signed({{3{vy_q[4]}}, vy_q});
   assign y_rise    = y_cur - $signed({4'd0, JUMP_V});
   assign y_floor_s = $signed({1'b0, Y_FLOOR});
   assign y_min_s   = $signed({1'b0, Y_MIN});
   assign vy_max_s  = $signed({1'b0, VY_MAX});
   assign vy_jump   = -$signed({1'b0, JUMP_V});
   assign vy_grav   = (vy_q >= vy_max_s) ? vy_max_s : vy_q + 5'sd1;
   assign grav_wrap = (grav_q == GRAV_DIV - 3'd1);
   // A jump arriving in the same cycle as the step counts as pending for that step.
   assign jump_req  = pend_q | bus.jump;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vy_d     = vy_q;
      grav_d   = grav_q;
      pend_d   = pend_q | bus.jump;
      landed_d = 1'b0;

      if (bus.step) begin
         pend_d = 1'b0;
         x_d    = x_clamped;
         if (state_q == S_GROUND) begin
            if (jump_req) begin
               y_d     = (y_rise <= y_min_s) ? Y_MIN : y_rise[6:0];
               vy_d    = vy_jump;
               grav_d  = 3'd0;
               state_d = S_AIR;
            end
         end else if (y_fall >= y_floor_s) begin
            y_d      = Y_FLOOR;
            vy_d     = 5'sd0;
            grav_d   = 3'd0;
            landed_d = 1'b1;
            state_d  = S_GROUND;
         end else begin
            grav_d = grav_wrap ? 3'd0 : grav_q + 3'd1;
            // Ceiling bump kills upward speed outright; the gravity counter keeps running.
            if (y_fall <= y_min_s && vy_q < 0) begin
               y_d  = Y_MIN;
               vy_d = 5'sd0;
            end else begin
               y_d = y_fall[6:0];
               if (grav_wrap)
                  vy_d = vy_grav;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_AIR;
         x_q      <= X_START;
         y_q      <= Y_START;
         vy_q     <= 5'sd0;
         grav_q   <= 3'd0;
         pend_q   <= 1'b0;
         landed_q <= 1'b0;
      end else begin
         // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vy_q     <= vy_d;
         grav_q   <= grav_d;
         pend_q   <= pend_d;
         landed_q <= landed_d;
      end
   end

   assign bus.x_out    = x_q;
   assign bus.y_out    = y_q;
   assign bus.grounded = (state_q == S_GROUND);
   assign bus.landed   = landed_q;

endmodule
